isq_age_scheduler: RTL and testbench

- Age-matrix select scheduler for the issue queue.
- Tracks which issue-queue entries are occupied and their relative dispatch age.
- Each cycle, picks up to ISSUE_WIDTH ready entries oldest-first and assigns them to the non-stalled ALU ports.
- Sits beside the issue queue storage: the queue supplies the per-entry operand-ready vector and consumes the grants to drive its issue outputs.

---
 rtl/isq_age_scheduler_if.sv | 29 ++
 rtl/isq_age_scheduler.sv | 106 ++++++++++
 tb/tb_isq_age_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/isq_age_scheduler_if.sv
// rtl/isq_age_scheduler_if.sv - issue-queue side bundle for the age-matrix scheduler
interface isq_age_scheduler_if #(
  parameter int ENTRIES     = 8,
  parameter int ISSUE_WIDTH = 2
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic                                  flush;
  logic [ISSUE_WIDTH-1:0]                alloc_en;
  logic [ISSUE_WIDTH-1:0][IDX_W-1:0]     alloc_idx;
  logic [ENTRIES-1:0]                    ready;
  logic [ISSUE_WIDTH-1:0]                port_stall;
  logic [ISSUE_WIDTH-1:0]                grant_valid;
  logic [ISSUE_WIDTH-1:0][IDX_W-1:0]     grant_idx;
  logic [ENTRIES-1:0]                    occupied;
  logic [IDX_W:0]                        free_count;
  logic                                  full;
  logic                                  alloc_err;

  modport master (
    output flush, alloc_en, alloc_idx, ready, port_stall,
    input  grant_valid, grant_idx, occupied, free_count, full, alloc_err
  );

  modport slave (
    input  flush, alloc_en, alloc_idx, ready, port_stall,
    output grant_valid, grant_idx, occupied, free_count, full, alloc_err
  );
endinterface

// File: rtl/isq_age_scheduler.sv
// rtl/isq_age_scheduler.sv - oldest-first select of ready issue-queue entries onto ALU ports
module isq_age_scheduler #(
  parameter int ENTRIES     = 8,
  parameter int ISSUE_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  isq_age_scheduler_if.slave   bus
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0]                occ_q, occ_d;
  logic [ENTRIES-1:0][ENTRIES-1:0]   older_q, older_d;
  logic                              err_q, err_d;

  logic [ISSUE_WIDTH-1:0]            gv;
  logic [ISSUE_WIDTH-1:0][IDX_W-1:0] gi;
  logic [ENTRIES-1:0]                grant_mask;
  logic [ENTRIES-1:0]                sel_remaining;
  logic                              sel_found;
  logic                              sel_blocked;
  logic [IDX_W:0]                    free_cnt;

  // Each free port takes the oldest remaining candidate, then removes it from the pool.
  always_comb begin
    gv            = '0;
    gi            = '0;
    grant_mask    = '0;
    sel_found     = 1'b0;
    sel_blocked   = 1'b0;
    sel_remaining = bus.ready & occ_q;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      if (!bus.flush && !bus.port_stall[p]) begin
        sel_found = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
          if (!sel_found && sel_remaining[i]) begin
            sel_blocked = 1'b0;
            for (int j = 0; j < ENTRIES; j++) begin
              if (j != i && sel_remaining[j] && older_q[j][i]) sel_blocked = 1'b1;
            end
            if (!sel_blocked) begin
              sel_found = 1'b1;
              gv[p]     = 1'b1;
              gi[p]     = IDX_W'(i);
            end
          end
        end
        if (sel_found) begin
          sel_remaining[gi[p]] = 1'b0;
          grant_mask[gi[p]]    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    occ_d   = occ_q;
    older_d = older_q;
    err_d   = err_q;
    if (bus.flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q & ~grant_mask;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        if (bus.alloc_en[k]) begin
          if (occ_q[bus.alloc_idx[k]] && !grant_mask[bus.alloc_idx[k]]) err_d = 1'b1;
          for (int m = k + 1; m < ISSUE_WIDTH; m++) begin
            if (bus.alloc_en[m] && bus.alloc_idx[m] == bus.alloc_idx[k]) err_d = 1'b1;
          end
        end
      end
      // Lanes are applied in order so an earlier lane's entry counts as older for later lanes.
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        if (bus.alloc_en[k]) begin
          for (int j = 0; j < ENTRIES; j++) older_d[j][bus.alloc_idx[k]] = occ_d[j];
          older_d[bus.alloc_idx[k]] = '0;
          occ_d[bus.alloc_idx[k]]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q   <= '0;
      older_q <= '0;
      err_q   <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      older_q <= older_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    free_cnt = (IDX_W+1)'(ENTRIES);
    for (int i = 0; i < ENTRIES; i++) free_cnt = free_cnt - (IDX_W+1)'(occ_q[i]);
  end

  assign bus.grant_valid = gv;
  assign bus.grant_idx   = gi;
  assign bus.occupied    = occ_q;
  assign bus.free_count  = free_cnt;
  assign bus.full        = free_cnt < (IDX_W+1)'(ISSUE_WIDTH);
  assign bus.alloc_err   = err_q;
endmodule

// File: tb/tb_isq_age_scheduler.sv
// tb/tb_isq_age_scheduler.sv - scoreboard bench for isq_age_scheduler
module tb_isq_age_scheduler;
  localparam int ENTRIES = 8;
  localparam int IW      = 2;

  typedef struct {
    logic [1:0] gv;
    logic [2:0] i0;
    logic [2:0] i1;
  } grant_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  grant_exp_t sb[$];

  isq_age_scheduler_if #(.ENTRIES(ENTRIES), .ISSUE_WIDTH(IW)) bus ();

  isq_age_scheduler #(.ENTRIES(ENTRIES), .ISSUE_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  task automatic push(input logic [1:0] gv, input logic [2:0] i0, input logic [2:0] i1);
    grant_exp_t e;
    e.gv = gv; e.i0 = i0; e.i1 = i1;
    sb.push_back(e);
  endtask

  task automatic clear_inputs();
    bus.flush      = 1'b0;
    bus.alloc_en   = '0;
    bus.alloc_idx  = '0;
    bus.ready      = '0;
    bus.port_stall = '0;
  endtask

  task automatic alloc(input logic [1:0] en, input logic [2:0] a0, input logic [2:0] a1);
    bus.alloc_en     = en;
    bus.alloc_idx[0] = a0;
    bus.alloc_idx[1] = a1;
  endtask

  // Sample grants mid-cycle against the scoreboard, then advance one clock.
  task automatic tick(input string tag);
    grant_exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_gv"},  int'(bus.grant_valid),  int'(e.gv));
      chk({tag, "_gi0"}, int'(bus.grant_idx[0]), int'(e.i0));
      chk({tag, "_gi1"}, int'(bus.grant_idx[1]), int'(e.i1));
    end
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    @(negedge clk);
    chk("rst_gv",   int'(bus.grant_valid), 0);
    chk("rst_occ",  int'(bus.occupied), 0);
    chk("rst_free", int'(bus.free_count), 8);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_err",  int'(bus.alloc_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    alloc(2'b11, 3'd3, 3'd5); push(2'b00, 0, 0); tick("a35");
    chk("a35_occ", int'(bus.occupied), 8'h28);
    bus.ready = 8'hff; push(2'b11, 3'd3, 3'd5); tick("g35");
    chk("g35_free", int'(bus.free_count), 8);
    bus.ready = 8'hff; push(2'b00, 0, 0); tick("idle");

    alloc(2'b01, 3'd7, 0); push(2'b00, 0, 0); tick("a7");
    alloc(2'b01, 3'd2, 0); push(2'b00, 0, 0); tick("a2");
    alloc(2'b01, 3'd6, 0); push(2'b00, 0, 0); tick("a6");
    alloc(2'b01, 3'd1, 0); push(2'b00, 0, 0); tick("a1");
    chk("a7261_free", int'(bus.free_count), 4);
    bus.ready = 8'h42; push(2'b11, 3'd6, 3'd1); tick("g61");
    bus.ready = 8'h84; push(2'b11, 3'd7, 3'd2); tick("g72");
    chk("g72_free", int'(bus.free_count), 8);

    alloc(2'b01, 3'd4, 0); push(2'b00, 0, 0); tick("a4");
    alloc(2'b01, 3'd0, 0); push(2'b00, 0, 0); tick("a0");
    bus.ready = 8'h11; bus.port_stall = 2'b01; push(2'b10, 3'd0, 3'd4); tick("stall");
    bus.ready = 8'h11; push(2'b01, 3'd0, 3'd0); tick("unstall");
    chk("unstall_free", int'(bus.free_count), 8);

    for (int k = 0; k < 4; k++) begin
      alloc(2'b11, 3'(2 * k), 3'(2 * k + 1)); push(2'b00, 0, 0); tick("fill");
    end
    chk("fill_occ",  int'(bus.occupied), 8'hff);
    chk("fill_free", int'(bus.free_count), 0);
    chk("fill_full", int'(bus.full), 1);
    bus.ready = 8'h03; alloc(2'b01, 3'd1, 0); push(2'b11, 3'd0, 3'd1); tick("realloc");
    chk("realloc_occ",  int'(bus.occupied), 8'hfe);
    chk("realloc_free", int'(bus.free_count), 1);
    chk("realloc_full", int'(bus.full), 1);
    chk("realloc_err",  int'(bus.alloc_err), 0);
    bus.ready = 8'h82; push(2'b11, 3'd7, 3'd1); tick("young");
    chk("young_occ", int'(bus.occupied), 8'h7c);

    bus.flush = 1'b1; bus.ready = 8'hff; alloc(2'b11, 3'd0, 3'd1);
    push(2'b00, 0, 0); tick("flush");
    chk("flush_occ",  int'(bus.occupied), 0);
    chk("flush_free", int'(bus.free_count), 8);
    chk("flush_err",  int'(bus.alloc_err), 0);

    alloc(2'b01, 3'd2, 0); push(2'b00, 0, 0); tick("e_a2");
    alloc(2'b01, 3'd2, 0); push(2'b00, 0, 0); tick("e_dup");
    chk("err_set", int'(bus.alloc_err), 1);
    chk("err_occ", int'(bus.occupied), 8'h04);
    bus.flush = 1'b1; push(2'b00, 0, 0); tick("e_flush");
    chk("err_sticky", int'(bus.alloc_err), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_err",  int'(bus.alloc_err), 0);
    chk("arst_occ",  int'(bus.occupied), 0);
    chk("arst_free", int'(bus.free_count), 8);
    rst = 1'b0;

    alloc(2'b11, 3'd5, 3'd5); push(2'b00, 0, 0); tick("collide");
    chk("collide_err", int'(bus.alloc_err), 1);
    chk("collide_occ", int'(bus.occupied), 8'h20);
    bus.ready = 8'hff; push(2'b01, 3'd5, 3'd0); tick("g5");
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
